mem_port_arbiter: RTL

Shares one 64-bit memory port between the core's instruction-fetch requester and data requester. Registers the winning request onto the memory bus and holds it while the memory side locks. Tracks the source of every outstanding read in an in-order tag FIFO, so responses are routed back to the requester that issued them. Sits between core and the memory/cache controller.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_tag_fifo.sv | 75 +++++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter:
//               requester tag encoding, access-order codes and R/W codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Source of an outstanding read, stored per entry in the tag FIFO
    typedef enum logic {
        TAG_INST = 1'b0,
        TAG_DATA = 1'b1
    } tag_t;

    // Access order (size) codes on the memory bus
    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;

    // Direction codes on the memory bus
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Fetches always move a full word
    localparam logic [3:0] MASK_ALL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/mem_arb_tag_fifo.sv
// ============================================================================
// Module      : mem_arb_tag_fifo
// Description : In-order FIFO of 1-bit requester tags. One entry per read in
//               flight; the head names the requester owning the next
//               response. DEPTH must be a power of two so pointers wrap
//               naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
)(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    tag_t             store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state
    always_comb begin
        full    = (count == FULL_COUNT);
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = store[rd_ptr];
    end

    // Tag storage carries no reset; only entries between the pointers are meaningful
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_tag;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the instruction-fetch and
//               data requesters. Round-robin arbitration into a registered
//               output slot that holds while memory locks; an in-order tag
//               FIFO routes each read response back to its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = $clog2(OUTSTANDING)
)(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    // Instruction fetch requester
    input  logic        iINST_REQ,
    output logic        oINST_LOCK,
    input  logic [31:0] iINST_ADDR,
    output logic        oINST_VALID,
    input  logic        iINST_BUSY,
    output logic [63:0] oINST_DATA,
    // Data requester
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_ORDER,
    input  logic [3:0]  iDATA_MASK,
    input  logic        iDATA_RW,
    input  logic [31:0] iDATA_ADDR,
    input  logic [31:0] iDATA_DATA,
    output logic        oDATA_VALID,
    input  logic        iDATA_BUSY,
    output logic [63:0] oDATA_DATA,
    // Memory side
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [1:0]  oMEM_ORDER,
    output logic [3:0]  oMEM_MASK,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    output logic        oMEM_BUSY,
    input  logic [63:0] iMEM_DATA
);

    // OUTSTANDING must be a power of two, at least 2, for the tag FIFO wrap

    tag_t last_grant;
    logic slot_free;
    logic inst_elig;
    logic data_elig;
    logic grant_inst;
    logic grant_data;
    logic inst_accept;
    logic data_accept;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    tag_t fifo_head;
    tag_t push_tag;
    logic resp_live;

    // Arbitration: reads need a free tag slot; writes never consume one.
    // A pop in this same cycle does not free a slot early.
    always_comb begin
        slot_free  = !oMEM_REQ || !iMEM_LOCK;
        data_elig  = iDATA_REQ && ((iDATA_RW == RW_WRITE) || !fifo_full);
        inst_elig  = iINST_REQ && !fifo_full;

        // On contention, whoever did not win last time takes the slot
        grant_data = data_elig && (!inst_elig || (last_grant == TAG_INST));
        grant_inst = inst_elig && !grant_data;

        data_accept = slot_free && grant_data;
        inst_accept = slot_free && grant_inst;

        oDATA_LOCK  = !data_accept;
        oINST_LOCK  = !inst_accept;
    end

    // Tag FIFO push side: every accepted read records its source
    always_comb begin
        fifo_push = inst_accept || (data_accept && (iDATA_RW == RW_READ));
        push_tag  = inst_accept ? TAG_INST : TAG_DATA;
    end

    // Response routing: a response only counts when a read is outstanding
    always_comb begin
        resp_live   = iMEM_VALID && !fifo_empty;
        oINST_VALID = resp_live && (fifo_head == TAG_INST);
        oDATA_VALID = resp_live && (fifo_head == TAG_DATA);
        oMEM_BUSY   = resp_live && ((fifo_head == TAG_DATA) ? iDATA_BUSY : iINST_BUSY);
        fifo_pop    = resp_live && !oMEM_BUSY;
        oINST_DATA  = iMEM_DATA;
        oDATA_DATA  = iMEM_DATA;
    end

    // Output slot: load the winner, hold while memory locks, drop REQ when drained
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oMEM_REQ   <= 1'b0;
            oMEM_ORDER <= '0;
            oMEM_MASK  <= '0;
            oMEM_RW    <= 1'b0;
            oMEM_ADDR  <= '0;
            oMEM_DATA  <= '0;
            last_grant <= TAG_INST;
        end else if (data_accept) begin
            oMEM_REQ   <= 1'b1;
            oMEM_ORDER <= iDATA_ORDER;
            oMEM_MASK  <= iDATA_MASK;
            oMEM_RW    <= iDATA_RW;
            oMEM_ADDR  <= iDATA_ADDR;
            oMEM_DATA  <= iDATA_DATA;
            last_grant <= TAG_DATA;
        end else if (inst_accept) begin
            oMEM_REQ   <= 1'b1;
            oMEM_ORDER <= ORDER_WORD;
            oMEM_MASK  <= MASK_ALL;
            oMEM_RW    <= RW_READ;
            oMEM_ADDR  <= iINST_ADDR;
            oMEM_DATA  <= '0;
            last_grant <= TAG_INST;
        end else if (slot_free) begin
            oMEM_REQ   <= 1'b0;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (PTR_W)
    ) u_tag_fifo (
        .clk      (iCLOCK),
        .rst      (iRESET_SYNC),
        .push     (fifo_push),
        .push_tag (push_tag),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

`default_nettype wire
